// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART byte port among NUM_REQ requesters, round-robin per packet,
// with an optional source-tag byte per packet and an abort for packets that stall mid-stream.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int HEADER_EN      = 1,
  parameter int TAG_BASE       = 'hA0,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_BITS-1:0]         tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
  output logic [15:0]                  timeout_cnt
);
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [STALL_W-1:0] STALL_MAX =
    STALL_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_TAG, S_DATA} state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     grant_reg, grant_next;
  logic [IDX_W-1:0]     last_grant_reg, last_grant_next;
  logic [STALL_W-1:0]   stall_reg, stall_next;
  logic [15:0]          timeout_cnt_reg, timeout_cnt_next;

  logic [DATA_BITS-1:0] req_bytes [NUM_REQ];
  logic [IDX_W-1:0]     rr_pick;
  int                   rr_dist;
  int                   rr_best;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_bytes[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
      assign req_ready[gi] = (state_reg == S_DATA) && (grant_reg == IDX_W'(gi)) && tx_ready;
    end
  endgenerate

  // Round-robin: pick the valid requester with the smallest distance past last_grant.
  always_comb begin
    rr_pick = last_grant_reg;
    rr_best = NUM_REQ;
    rr_dist = 0;
    for (int c = 0; c < NUM_REQ; c++) begin
      rr_dist = c - int'(last_grant_reg) - 1;
      if (rr_dist < 0) rr_dist = rr_dist + NUM_REQ;
      if (req_valid[c] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        rr_pick = IDX_W'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      grant_reg       <= '0;
      last_grant_reg  <= IDX_W'(NUM_REQ - 1);
      stall_reg       <= '0;
      timeout_cnt_reg <= '0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      last_grant_reg  <= last_grant_next;
      stall_reg       <= stall_next;
      timeout_cnt_reg <= timeout_cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_grant_next  = last_grant_reg;
    stall_next       = stall_reg;
    timeout_cnt_next = timeout_cnt_reg;
    tx_valid         = 1'b0;
    tx_data          = '0;
    case (state_reg)
      S_IDLE: begin
        if (|req_valid) begin
          grant_next = rr_pick;
          state_next = (HEADER_EN != 0) ? S_TAG : S_DATA;
        end
      end
      S_TAG: begin
        tx_valid = 1'b1;
        tx_data  = DATA_BITS'(TAG_BASE + int'(grant_reg));
        if (tx_ready) state_next = S_DATA;
      end
      S_DATA: begin
        tx_valid = req_valid[grant_reg];
        tx_data  = req_bytes[grant_reg];
        if (req_valid[grant_reg] && tx_ready) begin
          stall_next = '0;
          if (req_last[grant_reg]) begin
            last_grant_next = grant_reg;
            state_next      = S_IDLE;
          end
        end else if (!req_valid[grant_reg]) begin
          // Abort only while the source is silent, so no byte is ever cut short.
          if ((TIMEOUT_CYCLES != 0) && (stall_reg == STALL_MAX)) begin
            state_next      = S_IDLE;
            last_grant_next = grant_reg;
            stall_next      = '0;
            if (timeout_cnt_reg != 16'hFFFF) timeout_cnt_next = timeout_cnt_reg + 16'd1;
          end else begin
            stall_next = stall_reg + 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy        = (state_reg != S_IDLE);
  assign grant_idx   = grant_reg;
  assign timeout_cnt = timeout_cnt_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences and
// randomized packet traffic compared against a packet-level round-robin model.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] a_req_data;
  logic [3:0]  a_req_valid, a_req_last, a_req_ready;
  logic [7:0]  a_tx_data;
  logic        a_tx_valid, a_tx_ready, a_busy;
  logic [1:0]  a_grant_idx;
  logic [15:0] a_timeout_cnt;

  logic [31:0] b_req_data;
  logic [3:0]  b_req_valid, b_req_last, b_req_ready;
  logic [7:0]  b_tx_data;
  logic        b_tx_valid, b_tx_ready, b_busy;
  logic [1:0]  b_grant_idx;
  logic [15:0] b_timeout_cnt;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .HEADER_EN(1), .TAG_BASE('hA0), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst), .req_data(a_req_data), .req_valid(a_req_valid), .req_last(a_req_last),
    .req_ready(a_req_ready), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .busy(a_busy), .grant_idx(a_grant_idx), .timeout_cnt(a_timeout_cnt));

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .HEADER_EN(0), .TAG_BASE('hA0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req_data(b_req_data), .req_valid(b_req_valid), .req_last(b_req_last),
    .req_ready(b_req_ready), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .busy(b_busy), .grant_idx(b_grant_idx), .timeout_cnt(b_timeout_cnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] last;
    logic [7:0] d0;
    logic       tx_ready;
    logic       exp_tx_valid;
    logic [7:0] exp_tx_data;
    logic [3:0] exp_req_ready;
    logic       exp_busy;
  } vec_t;
  vec_t vecs [9];

  int passed = 0;
  int total  = 0;

  // Requester byte sources: {last, data} per entry.
  logic [8:0]  src_mem [4][64];
  int          src_len [4];
  int          src_pos [4];
  int          src_gap [4];
  bit          gap_en;
  bit          rnd_ready;
  logic        ready_const;
  logic [7:0]  exp_q [$];
  logic        obs_busy;
  logic [15:0] obs_tcnt;
  logic [1:0]  obs_grant;
  int          model_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_pos[i] < src_len[i]) begin
        a_req_data[i*8 +: 8] = src_mem[i][src_pos[i]][7:0];
        a_req_last[i]        = src_mem[i][src_pos[i]][8];
      end else begin
        a_req_data[i*8 +: 8] = 8'h00;
        a_req_last[i]        = 1'b0;
      end
      a_req_valid[i] = (src_pos[i] < src_len[i]) && (src_gap[i] == 0);
    end
    a_tx_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : ready_const;
  endtask

  task automatic step();
    logic [3:0] xfer;
    logic       hs;
    @(negedge clk);
    xfer      = a_req_valid & a_req_ready;
    hs        = a_tx_valid & a_tx_ready;
    obs_busy  = a_busy;
    obs_tcnt  = a_timeout_cnt;
    obs_grant = a_grant_idx;
    chk("req_ready_onehot", 32'($countones(a_req_ready) <= 1), 32'd1);
    if (hs) begin
      chk("tx_byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("tx_byte", 32'(a_tx_data), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (xfer[i]) begin
        if (gap_en && !src_mem[i][src_pos[i]][8]) src_gap[i] = $urandom_range(0, 4);
        src_pos[i]++;
      end else if (src_gap[i] > 0) begin
        src_gap[i]--;
      end
    end
    drive();
  endtask

  task automatic add_pkt(input int r, input int n, input logic [7:0] base, input bit end_last);
    for (int k = 0; k < n; k++) begin
      src_mem[r][src_len[r]] = {((k == n - 1) && end_last), base + 8'(k)};
      src_len[r]++;
    end
  endtask

  task automatic run_until_empty(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    step();
    while (obs_busy && k < 40) begin
      step();
      k++;
    end
    chk({name, "_idle"}, 32'(obs_busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0; src_pos[i] = 0; src_gap[i] = 0;
    end
    exp_q.delete();
    rnd_ready = 1'b0; ready_const = 1'b1; gap_en = 1'b0;
    drive();
    b_req_valid = '0; b_req_last = '0; b_req_data = '0; b_tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Packet-level reference: whole packets handed out round-robin from the last winner.
  task automatic model_round();
    int mcnt [4];
    int mlen [4][4];
    int mpos [4];
    int mk [4];
    int remaining = 0;
    int c = 0;
    for (int r = 0; r < 4; r++) begin
      src_len[r] = 0; src_pos[r] = 0; src_gap[r] = 0;
      mcnt[r] = $urandom_range(0, 3);
      for (int p = 0; p < mcnt[r]; p++) begin
        mlen[r][p] = $urandom_range(1, 4);
        add_pkt(r, mlen[r][p], 8'($urandom), 1'b1);
      end
      mpos[r] = 0; mk[r] = 0;
      remaining += mcnt[r];
    end
    while (remaining > 0) begin
      for (int j = 1; j <= 4; j++) begin
        c = (model_last + j) % 4;
        if (mk[c] < mcnt[c]) break;
      end
      exp_q.push_back(8'hA0 + 8'(c));
      for (int b = 0; b < mlen[c][mk[c]]; b++) exp_q.push_back(src_mem[c][mpos[c] + b][7:0]);
      mpos[c] += mlen[c][mk[c]];
      mk[c]++;
      remaining--;
      model_last = c;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    //            valid    last     d0     rdy   tx_v  tx_d   rreq     busy
    vecs[0] = {4'b0001, 4'b0000, 8'h11, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[1] = {4'b0001, 4'b0000, 8'h11, 1'b0, 1'b1, 8'hA0, 4'b0000, 1'b1};
    vecs[2] = {4'b0001, 4'b0000, 8'h11, 1'b1, 1'b1, 8'hA0, 4'b0000, 1'b1};
    vecs[3] = {4'b0001, 4'b0000, 8'h11, 1'b0, 1'b1, 8'h11, 4'b0000, 1'b1};
    vecs[4] = {4'b0001, 4'b0000, 8'h11, 1'b1, 1'b1, 8'h11, 4'b0001, 1'b1};
    vecs[5] = {4'b0001, 4'b0000, 8'h22, 1'b0, 1'b1, 8'h22, 4'b0000, 1'b1};
    vecs[6] = {4'b0001, 4'b0000, 8'h22, 1'b1, 1'b1, 8'h22, 4'b0001, 1'b1};
    vecs[7] = {4'b0001, 4'b0001, 8'h33, 1'b1, 1'b1, 8'h33, 4'b0001, 1'b1};
    vecs[8] = {4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0};

    a_req_data = '0; a_req_valid = '0; a_req_last = '0; a_tx_ready = 1'b0;
    do_reset();

    @(negedge clk);
    chk("reset_tx_valid", 32'(a_tx_valid), 32'd0);
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_grant_idx", 32'(a_grant_idx), 32'd0);
    chk("reset_timeout_cnt", 32'(a_timeout_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Single packet with tag, UART ready pulsed.
    for (int v = 0; v < 9; v++) begin
      a_req_valid = vecs[v].valid;
      a_req_last  = vecs[v].last;
      a_req_data  = {24'h0, vecs[v].d0};
      a_tx_ready  = vecs[v].tx_ready;
      @(negedge clk);
      chk($sformatf("t1_v%0d_tx_valid", v), 32'(a_tx_valid), 32'(vecs[v].exp_tx_valid));
      chk($sformatf("t1_v%0d_tx_data", v), 32'(a_tx_data), 32'(vecs[v].exp_tx_data));
      chk($sformatf("t1_v%0d_req_ready", v), 32'(a_req_ready), 32'(vecs[v].exp_req_ready));
      chk($sformatf("t1_v%0d_busy", v), 32'(a_busy), 32'(vecs[v].exp_busy));
      @(posedge clk);
      #1;
    end

    // All four requesters busy with 1-byte packets: order 0,1,2,3,0.
    do_reset();
    add_pkt(0, 1, 8'h10, 1'b1); add_pkt(0, 1, 8'h14, 1'b1);
    add_pkt(1, 1, 8'h11, 1'b1); add_pkt(2, 1, 8'h12, 1'b1); add_pkt(3, 1, 8'h13, 1'b1);
    exp_q = '{8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12, 8'hA3, 8'h13, 8'hA0, 8'h14};
    drive();
    run_until_empty("t2_rr_order", 200);
    wait_idle("t2");

    // Late requesters do not interrupt the granted packet; then 3 before 1.
    do_reset();
    add_pkt(2, 3, 8'h20, 1'b1);
    exp_q = '{8'hA2, 8'h20, 8'h21, 8'h22, 8'hA3, 8'h30, 8'hA1, 8'h10};
    drive();
    step();
    step();
    add_pkt(1, 1, 8'h10, 1'b1);
    add_pkt(3, 1, 8'h30, 1'b1);
    drive();
    run_until_empty("t3_mid_packet", 200);
    wait_idle("t3");

    // Stalled packet aborted after 16 silent cycles; next search starts at 2.
    do_reset();
    add_pkt(1, 1, 8'h55, 1'b0);
    exp_q = '{8'hA1, 8'h55};
    drive();
    run_until_empty("t4_partial", 100);
    n = 0;
    step();
    while (obs_busy && n < 100) begin
      n++;
      step();
    end
    chk("t4_stall_cycles", 32'(n), 32'd16);
    chk("t4_timeout_cnt", 32'(obs_tcnt), 32'd1);
    chk("t4_grant_after_abort", 32'(obs_grant), 32'd1);
    add_pkt(0, 1, 8'h40, 1'b1); add_pkt(1, 1, 8'h41, 1'b1); add_pkt(2, 1, 8'h42, 1'b1);
    exp_q = '{8'hA2, 8'h42, 8'hA0, 8'h40, 8'hA1, 8'h41};
    drive();
    run_until_empty("t4_after_abort", 200);
    wait_idle("t4");
    chk("t4_timeout_cnt_hold", 32'(obs_tcnt), 32'd1);

    // Reset in the middle of a 5-byte packet.
    add_pkt(2, 5, 8'h60, 1'b1);
    exp_q = '{8'hA2, 8'h60, 8'h61};
    drive();
    run_until_empty("t6_before_reset", 100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_tx_valid", 32'(a_tx_valid), 32'd0);
    chk("t6_tx_data", 32'(a_tx_data), 32'd0);
    chk("t6_req_ready", 32'(a_req_ready), 32'd0);
    chk("t6_busy", 32'(a_busy), 32'd0);
    chk("t6_grant_idx", 32'(a_grant_idx), 32'd0);
    chk("t6_timeout_cnt", 32'(a_timeout_cnt), 32'd0);
    do_reset();
    add_pkt(0, 1, 8'h70, 1'b1); add_pkt(3, 1, 8'h73, 1'b1);
    exp_q = '{8'hA0, 8'h70, 8'hA3, 8'h73};
    drive();
    run_until_empty("t6_fresh", 100);
    wait_idle("t6");

    // No header, UART held off for 50 cycles.
    b_req_valid = 4'b0001; b_req_last = 4'b0001; b_req_data = 32'h5A; b_tx_ready = 1'b0;
    @(negedge clk);
    chk("t5_idle_tx_valid", 32'(b_tx_valid), 32'd0);
    @(posedge clk);
    #1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!(b_tx_valid === 1'b1 && b_tx_data === 8'h5A && b_req_ready === 4'b0000 && b_busy === 1'b1)) bad++;
      @(posedge clk);
      #1;
    end
    chk("t5_hold_bad_cycles", 32'(bad), 32'd0);
    b_tx_ready = 1'b1;
    @(negedge clk);
    chk("t5_xfer_req_ready", 32'(b_req_ready), 32'd1);
    chk("t5_xfer_tx_data", 32'(b_tx_data), 32'h5A);
    @(posedge clk);
    #1;
    b_req_valid = '0; b_tx_ready = 1'b0;
    @(negedge clk);
    chk("t5_busy_after", 32'(b_busy), 32'd0);
    @(posedge clk);
    #1;

    // Random packet traffic against the packet-level model.
    do_reset();
    model_last = 3;
    rnd_ready = 1'b1;
    gap_en = 1'b1;
    for (int rd = 0; rd < 10; rd++) begin
      model_round();
      drive();
      run_until_empty($sformatf("rand%0d", rd), 2000);
      wait_idle($sformatf("rand%0d", rd));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
